// File: rtl/uart_rx_core.sv
// UART receive engine: synchronizes rx, detects the start bit, majority-votes
// three mid-bit samples per bit, assembles an LSB-first word and checks the stop
// bit. All bit timing advances only on cycles where the sampling strobe is high.
module uart_rx_core #(
   parameter int DATA_BITS = 8,
   parameter int DIVISION  = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sampling,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int CW = $clog2(DIVISION);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIVISION - 1);
   localparam logic [CW-1:0] CNT_S0   = CW'(DIVISION / 2 - 1);
   localparam logic [CW-1:0] CNT_S1   = CW'(DIVISION / 2);
   localparam logic [CW-1:0] CNT_S2   = CW'(DIVISION / 2 + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // 2-of-3 majority vote
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   logic          rx_meta;
   logic          rx_s;
   state_t        state, state_next;
   logic [CW-1:0] sample_cnt, sample_cnt_next;
   logic [2:0]    bit_cnt, bit_cnt_next;
   logic [7:0]    sh, sh_next;
   logic [2:0]    votes, votes_next;
   logic [7:0]    rx_data_next;
   logic          rx_valid_next;
   logic          frame_err_next;
   logic          vote_s;
   logic          stop_vote_s;
   logic [7:0]    word_s;

   // Vote over the three stored samples; the stop decision happens on the tick of
   // the third sample, so that one comes straight from the synchronizer.
   assign vote_s      = maj3(votes[0], votes[1], votes[2]);
   assign stop_vote_s = maj3(votes[0], votes[1], rx_s);
   assign word_s      = sh >> (8 - DATA_BITS);

   // Two-flop synchronizer for the asynchronous serial line (idles high)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Next-state, datapath and output-pulse decode; nothing moves without a tick
   always_comb begin
      state_next      = state;
      sample_cnt_next = sample_cnt;
      bit_cnt_next    = bit_cnt;
      sh_next         = sh;
      votes_next      = votes;
      rx_data_next    = rx_data;
      rx_valid_next   = 1'b0;
      frame_err_next  = 1'b0;
      if (sampling) begin
         if (state != IDLE) begin
            if (sample_cnt == CNT_S0) begin
               votes_next[0] = rx_s;
            end else if (sample_cnt == CNT_S1) begin
               votes_next[1] = rx_s;
            end else if (sample_cnt == CNT_S2) begin
               votes_next[2] = rx_s;
            end else begin
               votes_next = votes;
            end
            if (sample_cnt == CNT_LAST) begin
               sample_cnt_next = CNT_ZERO;
            end else begin
               sample_cnt_next = sample_cnt + CNT_ONE;
            end
         end else begin
            sample_cnt_next = sample_cnt;
         end
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_next      = START;
                  sample_cnt_next = CNT_ONE;
               end else begin
                  state_next = IDLE;
               end
            end
            START: begin
               if (sample_cnt == CNT_LAST) begin
                  if (vote_s) begin
                     state_next = IDLE;
                  end else begin
                     state_next   = DATA;
                     bit_cnt_next = 3'd0;
                  end
               end else begin
                  state_next = START;
               end
            end
            DATA: begin
               if (sample_cnt == CNT_LAST) begin
                  sh_next      = {vote_s, sh[7:1]};
                  bit_cnt_next = bit_cnt + 3'd1;
                  if (bit_cnt == BIT_LAST) begin
                     state_next = STOP;
                  end else begin
                     state_next = DATA;
                  end
               end else begin
                  state_next = DATA;
               end
            end
            STOP: begin
               if (sample_cnt == CNT_S2) begin
                  state_next      = IDLE;
                  sample_cnt_next = CNT_ZERO;
                  if (stop_vote_s) begin
                     rx_data_next  = word_s;
                     rx_valid_next = 1'b1;
                  end else begin
                     frame_err_next = 1'b1;
                  end
               end else begin
                  state_next = STOP;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end else begin
         state_next = state;
      end
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sample_cnt <= CNT_ZERO;
         bit_cnt    <= 3'd0;
         sh         <= 8'd0;
         votes      <= 3'd0;
         rx_data    <= 8'd0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_next;
         sample_cnt <= sample_cnt_next;
         bit_cnt    <= bit_cnt_next;
         sh         <= sh_next;
         votes      <= votes_next;
         rx_data    <= rx_data_next;
         rx_valid   <= rx_valid_next;
         frame_err  <= frame_err_next;
         busy       <= (state_next != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Testbench for uart_rx_core: a table of directed frames, hand-written corner
// sequences (glitch, real-rate back-to-back frames, reset mid-frame), and random
// frames checked against a frame-level decoding model.
module tb_uart_rx_core;

   localparam int D  = 16;
   localparam int DB = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sampling = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;

   int checks = 0;
   int failures = 0;

   typedef struct {
      bit         err;
      logic [7:0] data;
   } ev_t;

   typedef struct {
      logic [7:0] data;
      bit         stop;
      int         flip;
      bit         exp_err;
      logic [7:0] exp_data;
      int         exp_busy;
   } vec_t;

   ev_t        obs_q[$];
   ev_t        exp_q[$];
   bit         wave[$];
   int         busy_cnt = 0;
   bit         overlap = 1'b0;
   logic [7:0] model_good = 8'h00;
   vec_t       tbl[7];

   uart_rx_core #(.DATA_BITS(DB), .DIVISION(D)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sampling (sampling),
      .rx       (rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .frame_err(frame_err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Record output pulses and busy cycles away from the active edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid || frame_err) begin
            ev_t e;
            e.err  = frame_err;
            e.data = rx_data;
            obs_q.push_back(e);
         end
         if (busy) busy_cnt++;
         if (rx_valid && frame_err) overlap = 1'b1;
      end
   end

   task automatic chk(input bit ok, input string name, input int act, input int exp_v);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   task automatic add(input bit v, input int n);
      repeat (n) wave.push_back(v);
   endtask

   task automatic add_frame(input logic [7:0] d, input bit stop, input int stop_len);
      add(1'b0, D);
      for (int j = 0; j < DB; j++) add(d[j], D);
      add(stop, stop_len);
   endtask

   // Drive one wave element per tick; a tick is one strobe every 'period' clocks
   task automatic play(input int period, input int limit);
      for (int k = 0; k < wave.size() && k < limit; k++) begin
         rx = wave[k];
         for (int c = 0; c < period; c++) begin
            sampling = (period == 1) || (c == period / 2);
            @(posedge clk);
            #1;
         end
      end
      sampling = 1'b0;
   endtask

   function automatic bit wat(input int k);
      if (k >= 0 && k < wave.size()) return wave[k];
      return 1'b1;
   endfunction

   function automatic bit maj(input bit a, input bit b, input bit c);
      return (int'(a) + int'(b) + int'(c)) >= 2;
   endfunction

   // Frame-level decode of the tick waveform: each bit is voted at its mid
   // samples; a decided frame resumes searching right after its third stop sample
   task automatic model_run();
      int         i;
      logic [7:0] w;
      bit         sb;
      ev_t        e;
      i = 0;
      exp_q.delete();
      while (i < wave.size()) begin
         if (wat(i) == 1'b0) begin
            if (maj(wat(i + D/2 - 1), wat(i + D/2), wat(i + D/2 + 1))) begin
               i += D;
            end else begin
               w = 8'h00;
               for (int j = 0; j < DB; j++)
                  w[j] = maj(wat(i + D*(j+1) + D/2 - 1), wat(i + D*(j+1) + D/2),
                             wat(i + D*(j+1) + D/2 + 1));
               sb = maj(wat(i + D*(DB+1) + D/2 - 1), wat(i + D*(DB+1) + D/2),
                        wat(i + D*(DB+1) + D/2 + 1));
               if (sb) begin
                  model_good = w;
                  e.err = 1'b0;
               end else begin
                  e.err = 1'b1;
               end
               e.data = model_good;
               exp_q.push_back(e);
               i += D*(DB+1) + D/2 + 2;
            end
         end else begin
            i++;
         end
      end
   endtask

   task automatic compare_events(input string name);
      chk(obs_q.size() == exp_q.size(), {name, "_count"}, obs_q.size(), exp_q.size());
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
         chk(obs_q[k].err == exp_q[k].err && obs_q[k].data == exp_q[k].data,
             {name, "_event"}, {obs_q[k].err, obs_q[k].data}, {exp_q[k].err, exp_q[k].data});
      chk(rx_data == model_good, {name, "_rx_data"}, rx_data, model_good);
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int period;
      int nflip;
      int pos;

      tbl[0] = '{8'hA5, 1'b1, -1,         1'b0, 8'hA5, 153};
      tbl[1] = '{8'h3C, 1'b0, -1,         1'b1, 8'hA5, -1};
      tbl[2] = '{8'h3C, 1'b1, D*4 + 8,    1'b0, 8'h3C, 153};
      tbl[3] = '{8'h00, 1'b1, -1,         1'b0, 8'h00, 153};
      tbl[4] = '{8'hFF, 1'b1, D*9 + 7,    1'b0, 8'hFF, 153};
      tbl[5] = '{8'h81, 1'b1, D*1 + 9,    1'b0, 8'h81, 153};
      tbl[6] = '{8'h96, 1'b1, 8,          1'b0, 8'h96, 153};

      // Reset values
      #1;
      chk(rx_data == 8'h00, "reset_rx_data", rx_data, 0);
      chk(rx_valid == 1'b0, "reset_rx_valid", rx_valid, 0);
      chk(frame_err == 1'b0, "reset_frame_err", frame_err, 0);
      chk(busy == 1'b0, "reset_busy", busy, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed frames, one tick per clock
      for (int t = 0; t < 7; t++) begin
         wave.delete();
         obs_q.delete();
         busy_cnt = 0;
         add(1'b1, 4);
         add_frame(tbl[t].data, tbl[t].stop, D);
         add(1'b1, 20);
         if (tbl[t].flip >= 0) wave[4 + tbl[t].flip] = ~wave[4 + tbl[t].flip];
         play(1, wave.size());
         chk(obs_q.size() == 1, "tbl_pulse_count", obs_q.size(), 1);
         if (obs_q.size() >= 1) begin
            chk(obs_q[0].err == tbl[t].exp_err, "tbl_pulse_kind", obs_q[0].err, tbl[t].exp_err);
            chk(obs_q[0].data == tbl[t].exp_data, "tbl_pulse_data", obs_q[0].data, tbl[t].exp_data);
         end
         chk(rx_data == tbl[t].exp_data, "tbl_rx_data", rx_data, tbl[t].exp_data);
         if (tbl[t].exp_busy >= 0)
            chk(busy_cnt == tbl[t].exp_busy, "tbl_busy_len", busy_cnt, tbl[t].exp_busy);
      end
      model_good = 8'h96;

      // Start glitch of 5 ticks: abort after 16 ticks with no pulse
      wave.delete();
      obs_q.delete();
      busy_cnt = 0;
      add(1'b1, 4);
      add(1'b0, 5);
      add(1'b1, 30);
      play(1, wave.size());
      chk(obs_q.size() == 0, "glitch_no_pulse", obs_q.size(), 0);
      chk(busy_cnt == D - 1, "glitch_busy_len", busy_cnt, D - 1);
      chk(rx_data == 8'h96, "glitch_rx_data", rx_data, 8'h96);

      // Real-rate ticks, back-to-back frames with a 10-tick stop bit
      wave.delete();
      obs_q.delete();
      add(1'b1, 3);
      add_frame(8'h00, 1'b1, 10);
      add_frame(8'hFF, 1'b1, D);
      add(1'b1, 20);
      chk(obs_q.size() == 0, "rate_pre_empty", obs_q.size(), 0);
      play(27, wave.size());
      chk(obs_q.size() == 2 && obs_q[0].data == 8'h00 && obs_q[1].data == 8'hFF
          && !obs_q[0].err && !obs_q[1].err, "rate_two_words", obs_q.size(), 2);
      model_good = 8'h96;
      model_run();
      compare_events("rate");

      // Reset asserted during data bit 4
      wave.delete();
      obs_q.delete();
      add(1'b1, 4);
      add_frame(8'h3C, 1'b1, D);
      add(1'b1, 20);
      play(1, 4 + D*5 + 5);
      chk(busy == 1'b1, "midreset_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      chk(rx_data == 8'h00, "midreset_rx_data", rx_data, 0);
      chk(rx_valid == 1'b0, "midreset_rx_valid", rx_valid, 0);
      chk(frame_err == 1'b0, "midreset_frame_err", frame_err, 0);
      chk(busy == 1'b0, "midreset_busy", busy, 0);
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk(obs_q.size() == 0, "midreset_no_pulse", obs_q.size(), 0);
      model_good = 8'h00;
      wave.delete();
      add(1'b1, 4);
      add_frame(8'h5A, 1'b1, D);
      add(1'b1, 20);
      model_run();
      play(1, wave.size());
      chk(rx_data == 8'h5A, "after_reset_rx_data", rx_data, 8'h5A);
      compare_events("after_reset");

      // Random frames with noise, glitches and short or bad stop bits
      for (int r = 0; r < 25; r++) begin
         wave.delete();
         obs_q.delete();
         period = $urandom_range(1, 3);
         add(1'b1, $urandom_range(1, 6));
         if ($urandom_range(0, 3) == 0) begin
            add(1'b0, $urandom_range(1, 6));
            add(1'b1, 20);
         end
         pos = wave.size();
         add_frame(8'($urandom), ($urandom_range(0, 4) != 0), $urandom_range(10, 16));
         nflip = $urandom_range(0, 2);
         for (int f = 0; f < nflip; f++) begin
            int idx;
            idx = pos + D * $urandom_range(0, 9) + $urandom_range(D/2 - 1, D/2 + 1);
            wave[idx] = ~wave[idx];
         end
         add(1'b1, 170);
         model_run();
         play(period, wave.size());
         compare_events("rand");
      end

      chk(!overlap, "valid_err_overlap", overlap, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
